// File: rtl/clk_div_cascade_pkg.sv
// Shared constants and helpers for the cascaded stopwatch timebase.
package clk_div_cascade_pkg;

  // Default ratios: 100 MHz board clock down to 1 kHz, then decades.
  localparam int unsigned DIV_1K_AT_100M = 32'd100_000;
  localparam int unsigned DECADE         = 32'd10;

  // Counter width for a divide-by-ratio counter (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned ratio);
    if (ratio < 32'd3) begin
      return 32'd1;
    end else begin
      return $clog2(ratio);
    end
  endfunction

  // Ratios must be even and >= 2 so the divided clocks are exactly 50% duty.
  function automatic bit params_ok(input int unsigned div0,
                                   input int unsigned stage_div,
                                   input int unsigned n_stages);
    return (div0 >= 32'd2) && ((div0 % 32'd2) == 32'd0) &&
           (stage_div >= 32'd2) && ((stage_div % 32'd2) == 32'd0) &&
           (n_stages >= 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One divide-by-RATIO stage: wrapping counter, terminal-count flag and a
// registered 50%-duty half-period output.
module clk_div_stage
  import clk_div_cascade_pkg::*;
#(
  parameter int unsigned RATIO = DECADE,
  parameter int unsigned W     = cnt_width(RATIO)
) (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active-low
  input  logic         en,
  input  logic         clr,
  input  logic         adv,
  output logic         tc,
  output logic         half,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST  = W'(RATIO - 32'd1);
  localparam logic [W-1:0] HALFV = W'(RATIO / 32'd2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         half_q;
  logic         at_last_s;

  assign at_last_s = (cnt_q == LAST);
  // Terminal count excludes clr on purpose: the top masks the tick instead.
  assign tc   = en & adv & at_last_s;
  assign half = half_q;
  assign cnt  = cnt_q;

  // Next count: clear beats everything, otherwise advance and wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && adv) begin
      cnt_d = at_last_s ? '0 : (cnt_q + W'(1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and half-period flag; the flag follows the next count so its
  // falling edge lines up with the tick and its rising edge with mid-count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= (cnt_d >= HALFV);
    end
  end

endmodule

// File: rtl/clk_div_cascade.sv
// Cascaded stopwatch timebase: prescaler plus N_STAGES-1 equal stages, each
// producing a one-cycle tick and a 50%-duty divided clock.
// Optional macro CLK_DIV_CASCADE_CNT_OUT_EN exports the stage counters on cnt_out.
module clk_div_cascade
  import clk_div_cascade_pkg::*;
#(
  parameter int unsigned DIV0      = DIV_1K_AT_100M,
  parameter int unsigned STAGE_DIV = DECADE,
  parameter int unsigned N_STAGES  = 32'd4
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active-low
  input  logic                en,
  input  logic                clr,
  output logic [N_STAGES-1:0] tick,
`ifdef CLK_DIV_CASCADE_CNT_OUT_EN
  output logic [N_STAGES*cnt_width(STAGE_DIV)-1:0] cnt_out,
`endif
  output logic [N_STAGES-1:0] clk_out
);

  localparam int unsigned W0 = cnt_width(DIV0);
  localparam int unsigned W1 = cnt_width(STAGE_DIV);

  if (!params_ok(DIV0, STAGE_DIV, N_STAGES)) begin : g_bad_params
    $error("clk_div_cascade: ratios must be even and >= 2, N_STAGES >= 1");
  end

  logic [N_STAGES-1:0]         tc_s;
  logic [N_STAGES-1:0]         half_s;
  logic [N_STAGES-1:0]         tick_q, tick_d;
  logic [W0-1:0]               pre_cnt_s;
  logic [N_STAGES-1:0][W1-1:0] stage_cnt_s;
  logic                        unused_cnt_s;

  clk_div_stage #(
    .RATIO (DIV0),
    .W     (W0)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .adv   (1'b1),
    .tc    (tc_s[0]),
    .half  (half_s[0]),
    .cnt   (pre_cnt_s)
  );

  assign stage_cnt_s[0] = '0;

  for (genvar k = 1; k < N_STAGES; k++) begin : g_stage
    clk_div_stage #(
      .RATIO (STAGE_DIV),
      .W     (W1)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (clr),
      .adv   (tc_s[k-1]),
      .tc    (tc_s[k]),
      .half  (half_s[k]),
      .cnt   (stage_cnt_s[k])
    );
  end

`ifdef CLK_DIV_CASCADE_CNT_OUT_EN
  // Slice k-1 carries stage k; the top slice is always zero.
  assign cnt_out      = stage_cnt_s >> W1;
  assign unused_cnt_s = ^pre_cnt_s;
`else
  assign unused_cnt_s = ^{pre_cnt_s, stage_cnt_s};
`endif

  assign clk_out = half_s;
  assign tick    = tick_q;

  // A clear in the same cycle as a terminal count suppresses the tick.
  always_comb begin
    tick_d = '0;
    if (clr) begin
      tick_d = '0;
    end else begin
      tick_d = tc_s;
    end
  end

  // Registered tick strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: tb/tb_clk_div_cascade.sv
// Directed self-checking bench for clk_div_cascade (DIV0=10, STAGE_DIV=4, N_STAGES=3).
module tb_clk_div_cascade;

  localparam int unsigned DIV0 = 10;
  localparam int unsigned SD   = 4;
  localparam int unsigned NS   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          clr;
  logic [NS-1:0] tick;
  logic [NS-1:0] clk_out;
`ifdef CLK_DIV_CASCADE_CNT_OUT_EN
  logic [NS*2-1:0] cnt_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  always #5 clk = ~clk;

  clk_div_cascade #(
    .DIV0      (DIV0),
    .STAGE_DIV (SD),
    .N_STAGES  (NS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .tick    (tick),
`ifdef CLK_DIV_CASCADE_CNT_OUT_EN
    .cnt_out (cnt_out),
`endif
    .clk_out (clk_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after n enabled edges since the last reset/clear.
  task automatic check_run(input int nn);
    logic [2:0] et;
    logic [2:0] ec;
    et[0] = ((nn % 10) == 0);
    et[1] = ((nn % 40) == 0);
    et[2] = ((nn % 160) == 0);
    ec[0] = ((nn % 10) >= 5);
    ec[1] = ((nn % 40) >= 20);
    ec[2] = ((nn % 160) >= 80);
    if (nn == 0) et = 3'b000;
    check($sformatf("tick n=%0d", nn), 32'(tick), 32'(et));
    check($sformatf("clk_out n=%0d", nn), 32'(clk_out), 32'(ec));
`ifdef CLK_DIV_CASCADE_CNT_OUT_EN
    check($sformatf("cnt_out n=%0d", nn), 32'(cnt_out),
          32'({2'b00, 2'((nn / 40) % 4), 2'((nn / 10) % 4)}));
`endif
  endtask

  task automatic run_to(input int last);
    while (n < last) begin
      @(posedge clk);
      #1;
      n++;
      check_run(n);
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;

    // Reset held low for 100 ns.
    #40;
    check("reset tick", 32'(tick), 32'd0);
    check("reset clk_out", 32'(clk_out), 32'd0);
    #60;
    check("reset tick late", 32'(tick), 32'd0);

    // Release and run: ticks at 10/40/160, all coincide at 160.
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    n     = 0;
    run_to(206);

    // Pause at pre=6 for 37 cycles: no ticks, clk_out frozen at 3'b001.
    en = 1'b0;
    repeat (37) begin
      @(posedge clk);
      #1;
      check("pause tick", 32'(tick), 32'd0);
      check("pause clk_out", 32'(clk_out), 32'b001);
    end
    en = 1'b1;
    // Next tick[0] arrives on the 4th enabled edge (n=210).
    run_to(249);

    // Clear while pre==9: no tick, everything back to zero.
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr tick", 32'(tick), 32'd0);
    check("clr clk_out", 32'(clk_out), 32'd0);
    clr = 1'b0;
    n   = 0;
    run_to(40);

    // Asynchronous reset between edges while tick=3'b011.
    #3;
    reset = 1'b0;
    #1;
    check("async reset tick", 32'(tick), 32'd0);
    check("async reset clk_out", 32'(clk_out), 32'd0);

    // Restart: first tick[0] again at cycle 10.
    @(negedge clk);
    reset = 1'b1;
    n     = 0;
    run_to(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
